id_operand2_stage: RTL and testbench

ID_OPERAND2_STAGE -- requirements
Module: id_operand2_stage

---
 rtl/id_operand2_stage_if.sv | 28 ++
 rtl/id_operand2_stage.sv | 119 +++++++++++
 tb/tb_id_operand2_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_operand2_stage_if.sv
// Handshake and operand-2 payload bundle between ID decode and the operand-2 skid stage.
// master = upstream/EX environment, slave = the stage itself.
interface id_operand2_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_val_rm;
  logic              in_ready;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic              Val2_Src;
  logic [DATA_W-1:0] Imm;
  logic [11:0]       Shift_operand;
  logic [DATA_W-1:0] Val_Rm;
  logic              illegal;

  modport master (
    output in_valid, in_instr, in_val_rm, flush, out_ready,
    input  in_ready, out_valid, Val2_Src, Imm, Shift_operand, Val_Rm, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_val_rm, flush, out_ready,
    output in_ready, out_valid, Val2_Src, Imm, Shift_operand, Val_Rm, illegal
  );
endinterface

// File: rtl/id_operand2_stage.sv
// Operand-2 decode for ARM data-processing instructions, held in a two-entry
// (HEAD + SKID) buffer so in_ready can be registered without losing throughput.
module id_operand2_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  id_operand2_stage_if.slave   bus
);

  localparam int unsigned SHOP_W = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic              val2_src;
    logic [DATA_W-1:0] imm;
    logic [SHOP_W-1:0] shift_op;
    logic [DATA_W-1:0] val_rm;
    logic              illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t incoming;
  logic   out_valid_q;
  logic   in_ready_q;
  logic   illegal_q;
  logic   accept;
  logic   pop;

  logic [2*DATA_W-1:0] rot_dbl;
  logic [5:0]          rot_amt;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^{bus.in_instr[DATA_W-1:26], bus.in_instr[24:12]};

  // Rotate-right of the zero-extended imm8 by 2*rot, done as a shift of a doubled word.
  always_comb begin
    rot_amt           = {1'b0, bus.in_instr[11:8], 1'b0};
    rot_dbl           = {2{DATA_W'(bus.in_instr[7:0])}} >> rot_amt;
    incoming.val2_src = bus.in_instr[25];
    incoming.imm      = bus.in_instr[25] ? rot_dbl[DATA_W-1:0] : '0;
    incoming.shift_op = bus.in_instr[SHOP_W-1:0];
    incoming.val_rm   = bus.in_val_rm;
    incoming.illegal  = !bus.in_instr[25] && bus.in_instr[4];
  end

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = out_valid_q && bus.out_ready;

  // Next-state and entry movement; flush overrides everything, including the accept.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = incoming;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = incoming;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = incoming;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
      illegal_q   <= (state_d != EMPTY) && head_d.illegal;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.Val2_Src      = head_q.val2_src;
  assign bus.Imm           = head_q.imm;
  assign bus.Shift_operand = head_q.shift_op;
  assign bus.Val_Rm        = head_q.val_rm;
  assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_id_operand2_stage.sv
// Directed self-checking bench for id_operand2_stage.
// obs packs {out_valid, Val2_Src, Imm, Shift_operand, Val_Rm, illegal} for one-shot entry checks.
module tb_id_operand2_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_operand2_stage_if #(.DATA_W(32)) bus ();

  id_operand2_stage #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [78:0] obs;
  assign obs = {bus.out_valid, bus.Val2_Src, bus.Imm, bus.Shift_operand, bus.Val_Rm, bus.illegal};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rm);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_val_rm = rm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 79'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs, 79'h0);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_immediate();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hE3A004FF, 32'h0);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'hFF000000, 12'h4FF, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL imm_rot4 got %h exp %h", obs, {1'b1, 1'b1, 32'hFF000000, 12'h4FF, 32'h0, 1'b0});
    end
    drive(1'b1, 32'hE3A000AB, 32'h0);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h000000AB, 12'h0AB, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL imm_rot0 got %h exp %h", obs, {1'b1, 1'b1, 32'h000000AB, 12'h0AB, 32'h0, 1'b0});
    end
    drive(1'b1, 32'hE3A0010F, 32'h0);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'hC0000003, 12'h10F, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL imm_rot1_wrap got %h exp %h", obs, {1'b1, 1'b1, 32'hC0000003, 12'h10F, 32'h0, 1'b0});
    end
    drive(1'b1, 32'hE3A00F01, 32'h0);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h00000004, 12'hF01, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL imm_rot15 got %h exp %h", obs, {1'b1, 1'b1, 32'h00000004, 12'hF01, 32'h0, 1'b0});
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL imm_drain got valid=%b illegal=%b exp 0 0", bus.out_valid, bus.illegal);
    end
  endtask

  task automatic test_register();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hE1A00102, 32'h00000005);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 12'h102, 32'h5, 1'b0}) begin
      errors++;
      $display("FAIL reg_shift got %h exp %h", obs, {1'b1, 1'b0, 32'h0, 12'h102, 32'h5, 1'b0});
    end
    drive(1'b1, 32'hE1A00060, 32'h12345678);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 12'h060, 32'h12345678, 1'b0}) begin
      errors++;
      $display("FAIL reg_ror_rrx got %h exp %h", obs, {1'b1, 1'b0, 32'h0, 12'h060, 32'h12345678, 1'b0});
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hE1A00112, 32'h00000009);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 12'h112, 32'h9, 1'b1}) begin
      errors++;
      $display("FAIL illegal_regshift got %h exp %h", obs, {1'b1, 1'b0, 32'h0, 12'h112, 32'h9, 1'b1});
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clears got valid=%b illegal=%b exp 0 0", bus.out_valid, bus.illegal);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hE1A00000 | 32'(i), 32'h100 + 32'(i));
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.Val_Rm !== 32'h100 + 32'(i) || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d got valid=%b rm=%h rdy=%b exp 1 %h 1", i, bus.out_valid, bus.Val_Rm,
                 bus.in_ready, 32'h100 + 32'(i));
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hE1A00001, 32'hA);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.Val_Rm !== 32'hA) begin
      errors++;
      $display("FAIL bp_one got valid=%b rdy=%b rm=%h exp 1 1 a", bus.out_valid, bus.in_ready, bus.Val_Rm);
    end
    drive(1'b1, 32'hE1A00002, 32'hB);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.Val_Rm !== 32'hA) begin
      errors++;
      $display("FAIL bp_two got rdy=%b rm=%h exp 0 a", bus.in_ready, bus.Val_Rm);
    end
    drive(1'b1, 32'hE1A00003, 32'hC);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.Val_Rm !== 32'hA || bus.Shift_operand !== 12'h001) begin
      errors++;
      $display("FAIL bp_stall got rdy=%b rm=%h sh=%h exp 0 a 001", bus.in_ready, bus.Val_Rm, bus.Shift_operand);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Val_Rm !== 32'hB || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop_b got valid=%b rm=%h rdy=%b exp 1 b 1", bus.out_valid, bus.Val_Rm, bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Val_Rm !== 32'hC || bus.Shift_operand !== 12'h003) begin
      errors++;
      $display("FAIL bp_pop_c got valid=%b rm=%h sh=%h exp 1 c 003", bus.out_valid, bus.Val_Rm, bus.Shift_operand);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got valid=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hE1A00112, 32'hD);
    tick();
    drive(1'b1, 32'hE1A00005, 32'hE);
    tick();
    drive(1'b1, 32'hE3A000FF, 32'hF);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got valid=%b rdy=%b illegal=%b exp 0 1 0", bus.out_valid, bus.in_ready,
               bus.illegal);
    end
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_dropped got valid=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hE1A00112, 32'h77);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got valid=%b illegal=%b exp 1 1", bus.out_valid, bus.illegal);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 79'h0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now got %h rdy=%b exp 0 1", obs, bus.in_ready);
    end
    rst = 1'b0;
    drive(1'b1, 32'hE3A004FF, 32'h3);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'hFF000000, 12'h4FF, 32'h3, 1'b0}) begin
      errors++;
      $display("FAIL areset_accept got %h exp %h", obs, {1'b1, 1'b1, 32'hFF000000, 12'h4FF, 32'h3, 1'b0});
    end
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_immediate();
    test_register();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
